control_unit: RTL

//  Fixed-cycle microsequencer for the SAP-1.5 datapath; the initiator that drives the ALU.

---
 rtl/control_unit.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// Fixed-cycle microsequencer for the SAP-1.5 datapath: fetch, decode, per-cycle control word,
// ALU status flag register and conditional-jump evaluation.
module control_unit #(
    parameter int OPCODE_WIDTH = 4,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    alu_zero,
    input  logic                    alu_carry,
    input  logic                    alu_negative,
    output logic                    oe_pc,
    output logic                    oe_ram,
    output logic                    oe_ir,
    output logic                    oe_a,
    output logic                    oe_alu,
    output logic                    load_mar,
    output logic                    load_ir,
    output logic                    load_a,
    output logic                    load_b,
    output logic                    load_ram,
    output logic                    load_o,
    output logic                    load_pc,
    output logic                    pc_inc,
    output logic [1:0]              alu_op,
    output logic                    flag_zero,
    output logic                    flag_carry,
    output logic                    flag_negative,
    output logic                    halt
);

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_op_e;

    typedef enum logic [3:0] {
        OP_NOP    = 4'h0,
        OP_LDA    = 4'h1,
        OP_ADD    = 4'h2,
        OP_SUB    = 4'h3,
        OP_AND    = 4'h4,
        OP_OR     = 4'h5,
        OP_STA    = 4'h6,
        OP_LDI    = 4'h7,
        OP_JMP    = 4'h8,
        OP_JZ     = 4'h9,
        OP_JC     = 4'hA,
        OP_JN     = 4'hB,
        OP_RSVD_C = 4'hC,
        OP_RSVD_D = 4'hD,
        OP_OUT    = 4'hE,
        OP_HLT    = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        S_F1   = 3'd0,
        S_F2   = 3'd1,
        S_E1   = 3'd2,
        S_E2   = 3'd3,
        S_E3   = 3'd4,
        S_E4   = 3'd5,
        S_HALT = 3'd6
    } state_e;

    typedef struct packed {
        logic    oe_pc;
        logic    oe_ram;
        logic    oe_ir;
        logic    oe_a;
        logic    oe_alu;
        logic    load_mar;
        logic    load_ir;
        logic    load_a;
        logic    load_b;
        logic    load_ram;
        logic    load_o;
        logic    load_pc;
        logic    pc_inc;
        alu_op_e alu_op;
        logic    halt;
    } ctrl_t;

    state_e  state;
    state_e  state_next;
    ctrl_t   ctrl;
    opcode_e op;
    alu_op_e alu_sel;
    logic    is_alu;
    logic    load_flags;
    logic    jump_taken;
    logic    z_q;
    logic    c_q;
    logic    n_q;

    assign op = opcode_e'(opcode);

    always_comb begin
        is_alu  = 1'b1;
        alu_sel = ALU_ADD;
        case (op)
            OP_ADD:  alu_sel = ALU_ADD;
            OP_SUB:  alu_sel = ALU_SUB;
            OP_AND:  alu_sel = ALU_AND;
            OP_OR:   alu_sel = ALU_OR;
            default: is_alu  = 1'b0;
        endcase
    end

    // Conditional jumps look at the flags as last latched, never at the live ALU outputs.
    always_comb begin
        jump_taken = 1'b0;
        case (op)
            OP_JMP:  jump_taken = 1'b1;
            OP_JZ:   jump_taken = z_q;
            OP_JC:   jump_taken = c_q;
            OP_JN:   jump_taken = n_q;
            default: jump_taken = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_F1;
            z_q   <= 1'b0;
            c_q   <= 1'b0;
            n_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (load_flags) begin
                z_q <= alu_zero;
                c_q <= alu_carry;
                n_q <= alu_negative;
            end
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = ALU_ADD;
        load_flags  = 1'b0;
        state_next  = state;

        case (state)
            S_F1: begin
                ctrl.oe_pc    = 1'b1;
                ctrl.load_mar = 1'b1;
                state_next    = S_F2;
            end
            S_F2: begin
                ctrl.oe_ram  = 1'b1;
                ctrl.load_ir = 1'b1;
                ctrl.pc_inc  = 1'b1;
                state_next   = S_E1;
            end
            S_E1: begin
                state_next = S_F1;
                case (op)
                    OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        ctrl.oe_ir    = 1'b1;
                        ctrl.load_mar = 1'b1;
                        state_next    = S_E2;
                    end
                    OP_LDI: begin
                        ctrl.oe_ir  = 1'b1;
                        ctrl.load_a = 1'b1;
                    end
                    OP_JMP, OP_JZ, OP_JC, OP_JN: begin
                        ctrl.oe_ir   = jump_taken;
                        ctrl.load_pc = jump_taken;
                    end
                    OP_OUT: begin
                        ctrl.oe_a   = 1'b1;
                        ctrl.load_o = 1'b1;
                    end
                    OP_HLT:  state_next = S_HALT;
                    default: ;
                endcase
            end
            S_E2: begin
                state_next = S_F1;
                case (op)
                    OP_LDA: begin
                        ctrl.oe_ram = 1'b1;
                        ctrl.load_a = 1'b1;
                    end
                    OP_STA: begin
                        ctrl.oe_a     = 1'b1;
                        ctrl.load_ram = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        ctrl.oe_ram = 1'b1;
                        ctrl.load_b = 1'b1;
                        state_next  = S_E3;
                    end
                    default: ;
                endcase
            end
            S_E3: begin
                // The ALU result register latches on this edge together with the flags.
                ctrl.alu_op = alu_sel;
                load_flags  = is_alu;
                state_next  = is_alu ? S_E4 : S_F1;
            end
            S_E4: begin
                // alu_op is held from E3 so the ALU's latched result stays consistent.
                ctrl.alu_op = alu_sel;
                ctrl.oe_alu = 1'b1;
                ctrl.load_a = 1'b1;
                state_next  = S_F1;
            end
            S_HALT: begin
                ctrl.halt  = 1'b1;
                state_next = S_HALT;
            end
            default: state_next = S_F1;
        endcase

        // Reset silences the datapath immediately, so an aborted instruction never loads anything.
        if (reset) begin
            ctrl        = '0;
            ctrl.alu_op = ALU_ADD;
            load_flags  = 1'b0;
        end
    end

    assign oe_pc         = ctrl.oe_pc;
    assign oe_ram        = ctrl.oe_ram;
    assign oe_ir         = ctrl.oe_ir;
    assign oe_a          = ctrl.oe_a;
    assign oe_alu        = ctrl.oe_alu;
    assign load_mar      = ctrl.load_mar;
    assign load_ir       = ctrl.load_ir;
    assign load_a        = ctrl.load_a;
    assign load_b        = ctrl.load_b;
    assign load_ram      = ctrl.load_ram;
    assign load_o        = ctrl.load_o;
    assign load_pc       = ctrl.load_pc;
    assign pc_inc        = ctrl.pc_inc;
    assign alu_op        = ctrl.alu_op;
    assign halt          = ctrl.halt;
    assign flag_zero     = z_q;
    assign flag_carry    = c_q;
    assign flag_negative = n_q;

    a_bus_single_driver: assert property (@(posedge clk)
        $onehot0({oe_pc, oe_ram, oe_ir, oe_a, oe_alu}));

    a_pc_load_xor_inc: assert property (@(posedge clk) !(load_pc && pc_inc));

    a_halt_quiet: assert property (@(posedge clk)
        halt |-> !(|{oe_pc, oe_ram, oe_ir, oe_a, oe_alu, load_mar, load_ir, load_a,
                     load_b, load_ram, load_o, load_pc, pc_inc}));

    a_geometry: assert property (@(posedge clk)
        (OPCODE_WIDTH == 4) && (DATA_WIDTH > OPCODE_WIDTH));

endmodule
